// File: rtl/lt_int_serial_ctrl.sv
// Bit-serial integer less-than sequencer.
// LSB-first borrow chain, one operand bit per clock.
module lt_int_serial_ctrl #(
  parameter int WIDTH  = 16,
  parameter bit SIGNED = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         A,
  input  logic [WIDTH-1:0]         B,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     Y,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] bit_idx
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_nx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic            r_borrow;
  logic            r_y;
  logic [IW-1:0]   r_idx;

  logic w_last;
  logic w_flip;
  logic w_a;
  logic w_b;
  logic w_bn;

  assign w_last = (r_idx == LAST);

  // Flipping both sign bits maps signed order onto unsigned order.
  assign w_flip = SIGNED ? w_last : 1'b0;
  assign w_a    = r_a[r_idx] ^ w_flip;
  assign w_b    = r_b[r_idx] ^ w_flip;
  assign w_bn   = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: if (in_valid)  w_state_nx = S_RUN;
      S_RUN:  if (w_last)    w_state_nx = S_DONE;
      S_DONE: if (out_ready) w_state_nx = S_IDLE;
      default:               w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_borrow <= 1'b0;
      r_y      <= 1'b0;
      r_idx    <= '0;
    end else begin
      r_state <= w_state_nx;
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= A;
            r_b      <= B;
            r_borrow <= 1'b0;
            r_idx    <= '0;
          end
        end
        S_RUN: begin
          if (w_last) begin
            r_y   <= w_bn;
            r_idx <= '0;
          end else begin
            r_borrow <= w_bn;
            r_idx    <= r_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign Y         = r_y;
  assign bit_idx   = r_idx;

endmodule

// File: tb/tb_lt_int_serial_ctrl.sv
// Bench for lt_int_serial_ctrl: directed cases on 16-bit
// instances plus a random sweep over eight configurations.
module tb_lt_int_serial_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  iv;
  logic [7:0]  ordy;
  logic [63:0] a_s [8];
  logic [63:0] b_s [8];
  wire  [7:0]  ir;
  wire  [7:0]  ov;
  wire  [7:0]  yv;
  wire  [7:0]  bz;
  wire  [5:0]  bi [8];

  int errors;
  int checks;

  localparam int KS = 2;
  localparam int KU = 6;

  function automatic int wof(input int k);
    case (k % 4)
      0: return 2;
      1: return 8;
      2: return 16;
      default: return 32;
    endcase
  endfunction

  for (genvar k = 0; k < 8; k++) begin : g
    localparam int W = (k % 4 == 0) ? 2 :
                       (k % 4 == 1) ? 8 :
                       (k % 4 == 2) ? 16 : 32;
    localparam bit S = (k < 4);
    wire [$clog2(W)-1:0] idx;
    lt_int_serial_ctrl #(.WIDTH(W), .SIGNED(S)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (iv[k]),
      .in_ready (ir[k]),
      .A        (a_s[k][W-1:0]),
      .B        (b_s[k][W-1:0]),
      .out_valid(ov[k]),
      .out_ready(ordy[k]),
      .Y        (yv[k]),
      .busy     (bz[k]),
      .bit_idx  (idx)
    );
    assign bi[k] = 6'(idx);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit ref_lt(input logic [63:0] a,
                                input logic [63:0] b,
                                input int w, input bit s);
    logic [63:0] m;
    logic [63:0] ua;
    logic [63:0] ub;
    longint sa;
    longint sb;
    m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    ua = a & m;
    ub = b & m;
    if (s) begin
      sa = longint'(ua << (64 - w)) >>> (64 - w);
      sb = longint'(ub << (64 - w)) >>> (64 - w);
      return sa < sb;
    end
    return ua < ub;
  endfunction

  task automatic do_op(input int k, input logic [63:0] a,
                       input logic [63:0] b,
                       output logic yo, output int lat);
    a_s[k] = a;
    b_s[k] = b;
    iv[k]  = 1'b1;
    ordy[k] = 1'b0;
    @(posedge clk); #1;
    iv[k] = 1'b0;
    lat = -1;
    yo  = 1'bx;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (ov[k]) begin
        lat = n;
        break;
      end
    end
    if (lat > 0) yo = yv[k];
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if ({ir[k], ov[k], yv[k], bz[k]} !== 4'b1000 ||
          bi[k] !== 6'd0) begin
        errors++;
        $display("FAIL reset k=%0d got rdy/ov/y/busy=%b%b%b%b idx=%0d want 1000 idx=0",
                 k, ir[k], ov[k], yv[k], bz[k], bi[k]);
      end
    end
  endtask

  task automatic test_first_op();
    int bad;
    bad = 0;
    a_s[KS] = 64'hFFFF;
    b_s[KS] = 64'h0000;
    iv[KS]  = 1'b1;
    @(posedge clk); #1;
    iv[KS] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (bi[KS] !== 6'(i) || bz[KS] !== 1'b1 ||
          ov[KS] !== 1'b0 || ir[KS] !== 1'b0) begin
        bad++;
        $display("FAIL run_step i=%0d got idx=%0d busy=%b ov=%b rdy=%b",
                 i, bi[KS], bz[KS], ov[KS], ir[KS]);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) errors++;
    checks++;
    if (ov[KS] !== 1'b1 || yv[KS] !== 1'b1 || bi[KS] !== 6'd0) begin
      errors++;
      $display("FAIL first_result got ov=%b y=%b idx=%0d want ov=1 y=1 idx=0",
               ov[KS], yv[KS], bi[KS]);
    end
    ordy[KS] = 1'b1;
    @(posedge clk); #1;
    ordy[KS] = 1'b0;
  endtask

  task automatic test_signed_cases();
    logic [63:0] ta [3];
    logic [63:0] tb [3];
    logic        te [3];
    logic        y;
    int          lat;
    ta = '{64'h7FFF, 64'h8000, 64'h1234};
    tb = '{64'h8000, 64'h7FFF, 64'h1234};
    te = '{1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      do_op(KS, ta[i], tb[i], y, lat);
      checks++;
      if (y !== te[i] || lat != 16) begin
        errors++;
        $display("FAIL signed_%0d got y=%b lat=%0d want y=%b lat=16",
                 i, y, lat, te[i]);
      end
    end
  endtask

  task automatic test_unsigned_cases();
    logic y;
    int   lat;
    do_op(KU, 64'hFFFF, 64'h0000, y, lat);
    checks++;
    if (y !== 1'b0 || lat != 16) begin
      errors++;
      $display("FAIL unsigned_ffff got y=%b lat=%0d want y=0 lat=16", y, lat);
    end
    do_op(KU, 64'h0001, 64'h0002, y, lat);
    checks++;
    if (y !== 1'b1 || lat != 16) begin
      errors++;
      $display("FAIL unsigned_1_2 got y=%b lat=%0d want y=1 lat=16", y, lat);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    a_s[KS] = 64'h8000;
    b_s[KS] = 64'h7FFF;
    iv[KS]  = 1'b1;
    ordy[KS] = 1'b0;
    @(posedge clk); #1;
    iv[KS] = 1'b0;
    n = 0;
    while (!ov[KS] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (!ov[KS]) begin
      errors++;
      $display("FAIL bp_wait got ov=%b want 1", ov[KS]);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      iv[KS]  = 1'b1;
      a_s[KS] = 64'(i);
      b_s[KS] = 64'hFFFF;
      @(posedge clk); #1;
      if (ov[KS] !== 1'b1 || yv[KS] !== 1'b1 ||
          ir[KS] !== 1'b0 || bz[KS] !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold i=%0d got ov=%b y=%b rdy=%b busy=%b",
                 i, ov[KS], yv[KS], ir[KS], bz[KS]);
      end
    end
    checks++;
    if (bad != 0) errors++;
    iv[KS]   = 1'b0;
    ordy[KS] = 1'b1;
    @(posedge clk); #1;
    ordy[KS] = 1'b0;
    checks++;
    if (ir[KS] !== 1'b1 || ov[KS] !== 1'b0 ||
        yv[KS] !== 1'b1 || bz[KS] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release got rdy=%b ov=%b y=%b busy=%b want 1010",
               ir[KS], ov[KS], yv[KS], bz[KS]);
    end
  endtask

  task automatic test_reset_mid_run();
    int   seen;
    logic y;
    int   lat;
    a_s[KS] = 64'hFFFF;
    b_s[KS] = 64'h0000;
    iv[KS]  = 1'b1;
    @(posedge clk); #1;
    iv[KS] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    checks++;
    if (bi[KS] !== 6'd7) begin
      errors++;
      $display("FAIL mid_idx got %0d want 7", bi[KS]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({ir[KS], ov[KS], yv[KS], bz[KS]} !== 4'b1000 ||
        bi[KS] !== 6'd0) begin
      errors++;
      $display("FAIL mid_reset got rdy/ov/y/busy=%b%b%b%b idx=%0d want 1000",
               ir[KS], ov[KS], yv[KS], bz[KS], bi[KS]);
    end
    seen = 0;
    ordy[KS] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ov[KS]) seen++;
    end
    ordy[KS] = 1'b0;
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL mid_no_result got %0d valid cycles want 0", seen);
    end
    do_op(KS, 64'h0003, 64'h0005, y, lat);
    checks++;
    if (y !== 1'b1 || lat != 16) begin
      errors++;
      $display("FAIL post_reset got y=%b lat=%0d want y=1 lat=16", y, lat);
    end
  endtask

  task automatic test_random_sweep();
    bit expq [8][$];
    int accepted;
    int got;
    int pend;
    int cyc;
    bit e;
    accepted = 0;
    got = 0;
    cyc = 0;
    pend = 0;
    while ((accepted < 10000 || pend != 0) && cyc < 80000) begin
      @(posedge clk); #1;
      cyc++;
      for (int k = 0; k < 8; k++) begin
        iv[k]   = (accepted < 10000) && ($urandom % 3 != 0);
        a_s[k]  = {$urandom, $urandom};
        b_s[k]  = ($urandom % 8 == 0) ? a_s[k] : {$urandom, $urandom};
        if ($urandom % 6 == 0) b_s[k] = a_s[k] ^ (64'd1 << (wof(k) - 1));
        ordy[k] = ($urandom % 3 != 0);
      end
      @(negedge clk);
      pend = 0;
      for (int k = 0; k < 8; k++) begin
        if (iv[k] && ir[k]) begin
          expq[k].push_back(ref_lt(a_s[k], b_s[k], wof(k), k < 4));
          accepted++;
        end
        if (ov[k] && ordy[k]) begin
          checks++;
          got++;
          if (expq[k].size() == 0) begin
            errors++;
            $display("FAIL rand_extra k=%0d got y=%b want no result", k, yv[k]);
          end else begin
            e = expq[k].pop_front();
            if (yv[k] !== e) begin
              errors++;
              $display("FAIL rand_y k=%0d W=%0d got %b want %b",
                       k, wof(k), yv[k], e);
            end
          end
        end
        pend += expq[k].size();
      end
    end
    for (int k = 0; k < 8; k++) begin
      iv[k] = 1'b0;
      ordy[k] = 1'b0;
    end
    checks++;
    if (got != accepted || pend != 0) begin
      errors++;
      $display("FAIL rand_count got %0d results want %0d (pending %0d)",
               got, accepted, pend);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    iv     = '0;
    ordy   = '0;
    for (int k = 0; k < 8; k++) begin
      a_s[k] = '0;
      b_s[k] = '0;
    end
    test_reset();
    test_first_op();
    test_signed_cases();
    test_unsigned_cases();
    test_backpressure();
    test_reset_mid_run();
    test_random_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lt_int_serial_ctrl.md
Name: lt_int_serial_ctrl

Overview:
Bit-serial sequencer for integer less-than.
- Accepts an A/B operand pair over a valid/ready handshake and walks the bits LSB-first through a one-bit borrow-compare step, one bit per clock.
- Returns the 1-bit result over a valid/ready handshake.
- Models the row-serial execution order used in the PIM flow. It is the sequenced counterpart to the combinational n-bit signed comparator and must match it bit-exactly.

Parameters:
- WIDTH, 16, operand width in bits; legal range 2..64.
- SIGNED, 1, 1 = two's-complement compare; 0 = unsigned compare.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair A/B is valid.
- in_ready  output  1  controller can accept operands; high only in IDLE.
- A  input  WIDTH  left operand; sampled on the in_valid&&in_ready edge.
- B  input  WIDTH  right operand; sampled on the same edge.
- out_valid  output  1  Y holds a completed result.
- out_ready  input  1  consumer accepts Y.
- Y  output  1  1 when A < B (signed or unsigned per SIGNED).
- busy  output  1  high in RUN or DONE.
- bit_idx  output  clog2(WIDTH)  index of the bit processed this cycle; 0 outside RUN.

Behaviour:
- Reset: rst sampled high at a rising edge puts the block in IDLE with:
  - in_ready=1, out_valid=0, Y=0, busy=0, bit_idx=0;
  - internal borrow=0 and operand registers cleared.
  - rst overrides every other input, including mid-RUN and in DONE. Any in-flight operation is discarded and no result is produced.
- State IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch A and B, clear borrow, set bit_idx=0 and go to RUN.
  - in_valid=0 stays in IDLE.
- State RUN:
  - in_ready=0, out_valid=0.
  - Each cycle processes bit i=bit_idx with a=A_reg[i], b=B_reg[i]. When i==WIDTH-1 and SIGNED=1, both bits are inverted before use (MSB flip turns the signed compare into an unsigned compare).
  - borrow_next = (~a & b) | (~(a ^ b) & borrow).
  - If i<WIDTH-1: borrow<=borrow_next and bit_idx<=i+1.
  - If i==WIDTH-1: Y<=borrow_next, bit_idx<=0, go to DONE.
  - RUN lasts exactly WIDTH cycles and cannot be aborted except by rst.
- State DONE:
  - out_valid=1, Y stable, in_ready=0.
  - On an edge with out_ready=1, go to IDLE. Y holds its value until the next result is written.
  - out_ready=0 holds DONE indefinitely (backpressure). in_valid is ignored.
- Latency: accept edge at cycle T means out_valid is first high after edge T+WIDTH. Minimum throughput is one result per WIDTH+2 cycles; there is no overlap between operations.
- in_ready, out_valid and busy are decoded from registered state. No combinational path from in_valid or out_ready to any output.
- Equal operands give borrow 0, so Y=0.
- in_valid asserted during RUN/DONE is not accepted. The upstream must hold it until in_ready.
- Operand inputs are don't-care except on the accept edge.

Test Plan:
- WIDTH=16, SIGNED=1: A=16'hFFFF (-1), B=16'h0000 -> out_valid after exactly 16 edges past accept, Y=1; bit_idx steps 0..15 during RUN.
- SIGNED=1: A=16'h7FFF, B=16'h8000 -> Y=0. Then A=16'h8000, B=16'h7FFF -> Y=1. Then A=B=16'h1234 -> Y=0.
- SIGNED=0: A=16'hFFFF, B=16'h0000 -> Y=0. Then A=16'h0001, B=16'h0002 -> Y=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid and Y stay constant, in_ready=0, and a new in_valid is not accepted. Raise out_ready -> IDLE next edge, in_ready=1.
- Reset at bit_idx=7 of A=16'hFFFF, B=16'h0000 -> next cycle in IDLE with in_ready=1, out_valid=0, Y=0, busy=0, and no result emitted. A fresh A=16'h0003, B=16'h0005 then gives Y=1 after 16 edges.
- Random sweep: 10k random pairs with random in_valid/out_ready gaps, WIDTH in {2,8,16,32}, both SIGNED values -> Y matches a signed/unsigned reference model. Every result is accepted exactly once and in order.
